ifu_axi_fetch: RTL and testbench
================================

Name: ifu_axi_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Takes the fetch PC from the branch unit and issues one AXI4-Lite read per instruction.
- Extracts the 32-bit instruction from the 64-bit read beat.
- Presents {ins, pc} to IF/ID with a valid/ready handshake and supports flush/redirect while a read is outstanding.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI read data width; fixed at 64, instruction is word pc[2] of the beat.
- RESET_PC, 64'h8000_0000, PC emitted on the first fetch after reset.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pc  in  CPU_WIDTH  next fetch PC from branch unit; sampled only when a fetch starts
- i_flush  in  1  redirect/bubble from branch unit; kills in-flight or held instruction
- o_if_valid  out  1  instruction valid toward IF/ID
- i_id_ready  in  1  IF/ID can accept
- o_ins  out  INS_WIDTH  fetched instruction
- o_pc  out  CPU_WIDTH  PC of o_ins
- o_fetch_err  out  1  qualifies o_if_valid: RRESP != OKAY or misaligned PC
- o_arvalid  out  1  AXI AR valid
- i_arready  in  1  AXI AR ready
- o_araddr  out  ADDR_W  i_pc[ADDR_W-1:0] with bits [2:0] forced to 0
- i_rvalid  in  1  AXI R valid
- o_rready  out  1  AXI R ready
- i_rdata  in  DATA_W  AXI R data
- i_rresp  in  2  AXI R response

Behaviour:
- Reset values: o_if_valid=0, o_arvalid=0, o_rready=0, o_ins=32'h0000_0013 (nop), o_pc=RESET_PC, o_fetch_err=0, state=IDLE, kill=0.
- The first fetch after reset uses RESET_PC. Later fetches use i_pc.
- State IDLE:
  - Latch the fetch PC into the pc register.
  - Misaligned PC (pc[1:0]!=0): go directly to HOLD with o_fetch_err=1 and ins=nop. No AXI traffic.
  - Otherwise assert o_arvalid and go to AR.
- State AR:
  - o_arvalid held high; o_araddr stable until i_arready.
  - On handshake: deassert o_arvalid, go to R.
- State R:
  - o_rready=1.
  - On i_rvalid: ins = pc[2] ? rdata[63:32] : rdata[31:0]; o_fetch_err=(rresp!=2'b00).
  - If kill is 0: go to HOLD with o_if_valid=1.
  - If kill is 1: discard the beat, clear kill, go to IDLE.
- State HOLD:
  - o_if_valid=1; o_ins, o_pc and o_fetch_err stable.
  - On i_id_ready: drop valid and go to IDLE. The next fetch starts the same cycle, so o_arvalid rises one cycle after the transfer.
- i_flush rules:
  - In HOLD: drop valid and go to IDLE, regardless of i_id_ready.
  - In AR or R: set kill. The outstanding AXI transaction always completes; AR is never withdrawn.
  - In IDLE: no effect.
- Best-case throughput: 1 instruction per 3 cycles (IDLE→AR→R→HOLD, with AR and R each taking one cycle).
- Only one outstanding AXI transaction at a time.
- i_flush and i_rvalid in the same cycle in R: the beat is discarded.

Optional Feature:
- Macro IFU_BEAT_BUF_EN.
- When defined:
  - A single-entry buffer holds the last good 64-bit beat and its 8-byte-aligned address.
  - In IDLE, if the new PC hits the buffer, go straight to HOLD next cycle with the word selected by pc[2]. No AXI traffic.
  - Any beat with an error response is never buffered.
  - The buffer is invalidated on reset only.
- When not defined: every fetch goes to AXI.

Decomposition:
- Shared config package/header holds CPU_WIDTH, INS_WIDTH, RESET_PC, the fetch-state enum {IDLE,AR,R,HOLD}, AXI RESP constants, and the NOP encoding.
- One natural sub-module, ifu_beat_buf: the optional beat buffer, with tag compare and word select.

Test Plan:
- Reset release; memory returns 64'h0000_0073_0010_0093 for addr 0x8000_0000 → o_araddr=0x8000_0000, o_ins=0x0010_0093, o_pc=0x8000_0000, o_if_valid on the 3rd cycle after the fetch starts.
- i_pc=0x8000_0004 with the same beat → o_ins=0x0000_0073. With IFU_BEAT_BUF_EN: zero AR handshakes and o_if_valid one cycle after IDLE.
- i_id_ready=0 for 5 cycles in HOLD → o_ins and o_pc stable, no new AR; ready=1 → valid drops and AR reissues the next cycle.
- i_flush asserted while in R, with i_rvalid 2 cycles later → no o_if_valid for that beat; the next AR uses the new i_pc=0x8000_0100.
- i_rresp=2'b10 → o_if_valid=1 with o_fetch_err=1; the beat is not buffered, so a refetch of the same address issues AR.
- i_pc=0x8000_0002 → o_fetch_err=1, o_ins=0x0000_0013, and o_arvalid never rises.

Source files
------------

// File: rtl/ifu_axi_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_axi_fetch_pkg
// Shared configuration for the instruction-fetch stage: core/instruction
// widths, the default reset PC, the NOP encoding, AXI response codes and the
// fetch state encoding. Imported by every file of the fetch slice.
// ---------------------------------------------------------------------------
package ifu_axi_fetch_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // addi x0, x0, 0
  localparam logic [INS_WIDTH-1:0] INS_NOP = 32'h0000_0013;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_axi_fetch_if
// AXI4-Lite read-channel bundle between the fetch stage and instruction memory.
//   arvalid/arready/araddr : read address channel
//   rvalid/rready/rdata/rresp : read data channel
// Modports: master (fetch stage side), slave (memory side).
// ---------------------------------------------------------------------------
interface ifu_axi_fetch_if
  import ifu_axi_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid,
    input  arready,
    output araddr,
    input  rvalid,
    output rready,
    input  rdata,
    input  rresp
  );

  modport slave (
    input  arvalid,
    output arready,
    input  araddr,
    output rvalid,
    input  rready,
    output rdata,
    output rresp
  );

endinterface

// File: rtl/ifu_axi_fetch_beat_buf.sv
// ---------------------------------------------------------------------------
// ifu_beat_buf
// Single-entry buffer holding the last good 64-bit read beat and its
// 8-byte-aligned address tag. A lookup hits when the buffer is valid and the
// tag matches; the selected 32-bit word is chosen by the PC's bit 2.
// Only compiled when IFU_BEAT_BUF_EN is defined.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (invalidates entry)
//   wr_en           : capture wr_tag/wr_data
//   wr_tag, wr_data : aligned address tag and beat to store
//   rd_tag, rd_hi   : lookup tag and upper/lower word select
//   hit, word       : lookup result and selected instruction word
// ---------------------------------------------------------------------------
`ifdef IFU_BEAT_BUF_EN
module ifu_beat_buf
  import ifu_axi_fetch_pkg::*;
#(
  parameter int TAG_W  = 29,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [TAG_W-1:0]     rd_tag,
  input  logic                 rd_hi,
  output logic                 hit,
  output logic [INS_WIDTH-1:0] word
);

  logic              entry_valid;
  logic [TAG_W-1:0]  entry_tag;
  logic [DATA_W-1:0] entry_data;

  // The entry is only ever replaced by a newer good beat; nothing but reset
  // invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= 1'b0;
      entry_tag   <= '0;
      entry_data  <= '0;
    end else if (wr_en) begin
      entry_valid <= 1'b1;
      entry_tag   <= wr_tag;
      entry_data  <= wr_data;
    end
  end

  assign hit  = entry_valid && (entry_tag == rd_tag);
  assign word = rd_hi ? entry_data[63:32] : entry_data[31:0];

endmodule
`endif

// File: rtl/ifu_axi_fetch.sv
// ---------------------------------------------------------------------------
// ifu_axi_fetch
// Instruction-fetch stage feeding the IF/ID register. Issues one AXI4-Lite
// read per instruction, extracts the 32-bit word selected by pc[2] from the
// 64-bit beat and offers {ins, pc} to IF/ID with a valid/ready handshake.
// A flush while a read is outstanding lets the read finish and drops its beat.
// Optional feature: define IFU_BEAT_BUF_EN to add a one-beat buffer that
// serves repeat fetches of the same 8-byte line without AXI traffic.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pc           : next fetch PC (sampled when a fetch starts)
//   i_flush        : kill the in-flight or held instruction
//   o_if_valid, i_id_ready : handshake toward IF/ID
//   o_ins, o_pc, o_fetch_err : instruction, its PC and error qualifier
//   axi            : AXI4-Lite read channels (master modport)
// ---------------------------------------------------------------------------
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int                   ADDR_W   = 32,
  parameter int                   DATA_W   = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic                 i_flush,
  output logic                 o_if_valid,
  input  logic                 i_id_ready,
  output logic [INS_WIDTH-1:0] o_ins,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_fetch_err,
  ifu_axi_fetch_if.master      axi
);

  fetch_state_e         state;
  logic                 first_fetch;
  logic                 kill;
  logic                 arvalid_q;
  logic                 rready_q;
  logic [CPU_WIDTH-1:0] fetch_pc;
  logic                 misaligned;
  logic                 start_fetch;
  logic                 beat_okay;
  logic [INS_WIDTH-1:0] beat_word;

  // The very first fetch out of reset ignores the branch unit.
  assign fetch_pc   = first_fetch ? RESET_PC : i_pc;
  assign misaligned = (fetch_pc[1:0] != 2'b00);

  // A fetch starts from IDLE, or in the same cycle the held instruction is
  // accepted so that back-to-back fetches need only three cycles each.
  assign start_fetch = (state == IDLE) ||
                       ((state == HOLD) && i_id_ready && !i_flush);

  assign beat_okay = (axi.rresp == RESP_OKAY);
  assign beat_word = o_pc[2] ? axi.rdata[63:32] : axi.rdata[31:0];

  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.araddr  = {o_pc[ADDR_W-1:3], 3'b000};

`ifdef IFU_BEAT_BUF_EN
  logic                 buf_hit;
  logic [INS_WIDTH-1:0] buf_word;
  logic                 buf_wr;

  // Any OKAY beat is real memory content, even one whose instruction was
  // killed, so it is worth keeping; error beats never enter the buffer.
  assign buf_wr = (state == R) && axi.rvalid && beat_okay;

  ifu_beat_buf #(
    .TAG_W (ADDR_W - 3),
    .DATA_W(DATA_W)
  ) u_beat_buf (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_en  (buf_wr),
    .wr_tag (o_pc[ADDR_W-1:3]),
    .wr_data(axi.rdata),
    .rd_tag (fetch_pc[ADDR_W-1:3]),
    .rd_hi  (fetch_pc[2]),
    .hit    (buf_hit),
    .word   (buf_word)
  );
`endif

  // Fetch FSM. The per-state case handles the AXI handshakes and IF/ID
  // release; the trailing start_fetch block then overrides the next state
  // whenever a new fetch begins this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      first_fetch <= 1'b1;
      kill        <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      o_if_valid  <= 1'b0;
      o_ins       <= INS_NOP;
      o_pc        <= RESET_PC;
      o_fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        AR: begin
          // The address is never withdrawn; a flush only marks the beat dead.
          if (i_flush) begin
            kill <= 1'b1;
          end
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            if (kill || i_flush) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              o_ins       <= beat_word;
              o_fetch_err <= !beat_okay;
              o_if_valid  <= 1'b1;
              state       <= HOLD;
            end
          end else if (i_flush) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (i_flush || i_id_ready) begin
            o_if_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (start_fetch) begin
        first_fetch <= 1'b0;
        o_pc        <= fetch_pc;
        if (misaligned) begin
          // Report the fault without touching the bus.
          o_if_valid  <= 1'b1;
          o_ins       <= INS_NOP;
          o_fetch_err <= 1'b1;
          state       <= HOLD;
        end
`ifdef IFU_BEAT_BUF_EN
        else if (buf_hit) begin
          o_if_valid  <= 1'b1;
          o_ins       <= buf_word;
          o_fetch_err <= 1'b0;
          state       <= HOLD;
        end
`endif
        else begin
          arvalid_q   <= 1'b1;
          o_fetch_err <= 1'b0;
          state       <= AR;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_axi_fetch
// Directed self-checking bench for ifu_axi_fetch. The bench plays the AXI
// memory and the IF/ID consumer; expected instructions are queued when a
// fetch is requested and compared when o_if_valid appears.
// Expectations adapt when IFU_BEAT_BUF_EN is defined.
// ---------------------------------------------------------------------------
module tb_ifu_axi_fetch;
  import ifu_axi_fetch_pkg::*;

  typedef struct packed {
    logic [INS_WIDTH-1:0] ins;
    logic [CPU_WIDTH-1:0] pc;
    logic                 err;
  } exp_t;

  localparam logic [63:0] B0 = 64'h0000_0073_0010_0093;
  localparam logic [63:0] B1 = 64'hBAD0_BAD1_BAD2_BAD3;
  localparam logic [63:0] B2 = 64'h1111_1111_2222_2222;
  localparam logic [63:0] B3 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] B4 = 64'h0050_0093_0040_0093;
  localparam logic [63:0] B5 = 64'h0000_0000_00C0_0113;

  logic                 clk;
  logic                 rst_n;
  logic [CPU_WIDTH-1:0] pc_in;
  logic                 flush;
  logic                 if_valid;
  logic                 id_ready;
  logic [INS_WIDTH-1:0] ins;
  logic [CPU_WIDTH-1:0] pc_out;
  logic                 fetch_err;

  int checks      = 0;
  int errors      = 0;
  int ar_count    = 0;
  int ar_expected = 0;
  exp_t sb[$];

  ifu_axi_fetch_if #(.ADDR_W(32), .DATA_W(64)) axi ();

  ifu_axi_fetch #(
    .ADDR_W  (32),
    .DATA_W  (64),
    .RESET_PC(64'h0000_0000_8000_0000)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pc       (pc_in),
    .i_flush    (flush),
    .o_if_valid (if_valid),
    .i_id_ready (id_ready),
    .o_ins      (ins),
    .o_pc       (pc_out),
    .o_fetch_err(fetch_err),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed AR handshakes independently of the stimulus.
  always @(posedge clk) begin
    if (rst_n && axi.arvalid && axi.arready) ar_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [63:0] beat,
                                    input logic [63:0] pc,
                                    input logic [1:0]  resp);
    exp_t e;
    e.ins = pc[2] ? beat[63:32] : beat[31:0];
    e.pc  = pc;
    e.err = (resp != RESP_OKAY);
    return e;
  endfunction

  // Memory side: wait for AR, accept it, return one beat immediately.
  task automatic serve_read(input string tag, input logic [31:0] addr,
                            input logic [63:0] beat, input logic [1:0] resp);
    int n = 0;
    while (axi.arvalid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_output({tag, "_arvalid"}, axi.arvalid, 1);
    check_output({tag, "_araddr"}, axi.araddr, addr);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    ar_expected++;
    check_output({tag, "_rready"}, axi.rready, 1);
    axi.rvalid = 1'b1;
    axi.rdata  = beat;
    axi.rresp  = resp;
    tick();
    axi.rvalid = 1'b0;
  endtask

  // Consumer side: wait for valid and compare against the scoreboard head.
  task automatic pop_check(input string tag);
    exp_t e;
    int n = 0;
    while (if_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_output({tag, "_valid"}, if_valid, 1);
    check_output({tag, "_sb_entry"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output({tag, "_ins"}, ins, e.ins);
      check_output({tag, "_pc"}, pc_out, e.pc);
      check_output({tag, "_err"}, fetch_err, e.err);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] next_pc);
    pc_in    = next_pc;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    id_ready    = 1'b0;
    pc_in       = 64'h8000_0004;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = RESP_OKAY;
    repeat (3) tick();

    check_output("rst_valid", if_valid, 0);
    check_output("rst_arvalid", axi.arvalid, 0);
    check_output("rst_rready", axi.rready, 0);
    check_output("rst_ins", ins, 32'h0000_0013);
    check_output("rst_pc", pc_out, 64'h8000_0000);
    check_output("rst_err", fetch_err, 0);

    // First fetch ignores i_pc and uses the reset PC; valid on 3rd cycle.
    rst_n = 1'b1;
    sb.push_back(make_exp(B0, 64'h8000_0000, RESP_OKAY));
    tick();
    check_output("first_arvalid", axi.arvalid, 1);
    check_output("first_araddr", axi.araddr, 32'h8000_0000);
    check_output("first_valid_low", if_valid, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    ar_expected++;
    check_output("first_ar_drop", axi.arvalid, 0);
    check_output("first_rready", axi.rready, 1);
    axi.rvalid = 1'b1;
    axi.rdata  = B0;
    axi.rresp  = RESP_OKAY;
    tick();
    axi.rvalid = 1'b0;
    check_output("first_latency", if_valid, 1);
    pop_check("first");

    // Consumer stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("stall_valid", if_valid, 1);
      check_output("stall_ins", ins, 32'h0010_0093);
      check_output("stall_pc", pc_out, 64'h8000_0000);
      check_output("stall_no_ar", axi.arvalid, 0);
    end

    // Upper word of the same beat.
    sb.push_back(make_exp(B0, 64'h8000_0004, RESP_OKAY));
    apply_stimulus(64'h8000_0004);
`ifdef IFU_BEAT_BUF_EN
    check_output("hit_no_ar", axi.arvalid, 0);
    check_output("hit_valid", if_valid, 1);
`else
    check_output("reissue_ar", axi.arvalid, 1);
    check_output("reissue_valid_low", if_valid, 0);
    serve_read("second", 32'h8000_0000, B0, RESP_OKAY);
`endif
    pop_check("second");

    // Flush while in R; beat returns two cycles later and is dropped.
    apply_stimulus(64'h8000_0008);
    check_output("flush_arvalid", axi.arvalid, 1);
    check_output("flush_araddr", axi.araddr, 32'h8000_0008);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    ar_expected++;
    check_output("flush_rready", axi.rready, 1);
    flush = 1'b1;
    pc_in = 64'h8000_0100;
    tick();
    flush = 1'b0;
    check_output("flush_wait_valid", if_valid, 0);
    tick();
    axi.rvalid = 1'b1;
    axi.rdata  = B1;
    axi.rresp  = RESP_OKAY;
    tick();
    axi.rvalid = 1'b0;
    check_output("killed_no_valid", if_valid, 0);
    check_output("killed_no_ar", axi.arvalid, 0);
    check_output("killed_rready", axi.rready, 0);
    tick();
    check_output("killed_no_valid2", if_valid, 0);
    sb.push_back(make_exp(B2, 64'h8000_0100, RESP_OKAY));
    serve_read("redirect", 32'h8000_0100, B2, RESP_OKAY);
    pop_check("redirect");

    // Error response, then refetch of the same address must go to AXI.
    sb.push_back(make_exp(B3, 64'h8000_0204, RESP_SLVERR));
    apply_stimulus(64'h8000_0204);
    serve_read("err", 32'h8000_0200, B3, RESP_SLVERR);
    pop_check("err");
    sb.push_back(make_exp(B4, 64'h8000_0204, RESP_OKAY));
    apply_stimulus(64'h8000_0204);
    check_output("refetch_ar", axi.arvalid, 1);
    serve_read("refetch", 32'h8000_0200, B4, RESP_OKAY);
    pop_check("refetch");

    // Misaligned PC: error with NOP, no bus traffic.
    sb.push_back(exp_t'{ins: INS_NOP, pc: 64'h8000_0002, err: 1'b1});
    apply_stimulus(64'h8000_0002);
    check_output("misaligned_no_ar", axi.arvalid, 0);
    pop_check("misaligned");
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("misaligned_hold_no_ar", axi.arvalid, 0);
      check_output("misaligned_hold_valid", if_valid, 1);
    end

    // Flush in HOLD drops valid without id_ready.
    flush = 1'b1;
    pc_in = 64'h8000_0300;
    tick();
    flush = 1'b0;
    check_output("hold_flush_valid", if_valid, 0);
    check_output("hold_flush_no_ar", axi.arvalid, 0);
    sb.push_back(make_exp(B5, 64'h8000_0300, RESP_OKAY));
    serve_read("after_flush", 32'h8000_0300, B5, RESP_OKAY);
    pop_check("after_flush");
    apply_stimulus(64'h8000_0400);
    tick();

    check_output("ar_handshakes", ar_count, ar_expected);
    check_output("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
